// File: rtl/inst_rom_if.sv
// -----------------------------------------------------------------------------
// inst_rom_if -- fetch / boot-load bundle between the PC register side
// (master) and the instruction memory responder (slave).
//
//   ce, addr     : fetch request (addr is the byte PC)
//   stall        : pipeline stall vector, only bit 1 (IF hold) matters here
//   ld_we/addr/data : boot-load write port (word index)
//   inst, inst_valid, addr_err, parity_err : registered fetch response
// -----------------------------------------------------------------------------
interface inst_rom_if #(
    parameter int DEPTH_LOG2 = 10,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  ce;
    logic [ADDR_WIDTH-1:0] addr;
    logic [5:0]            stall;
    logic                  ld_we;
    logic [DEPTH_LOG2-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [DATA_WIDTH-1:0] inst;
    logic                  inst_valid;
    logic                  addr_err;
    logic                  parity_err;

    modport master (
        output ce, addr, stall, ld_we, ld_addr, ld_data,
        input  inst, inst_valid, addr_err, parity_err
    );

    modport slave (
        input  ce, addr, stall, ld_we, ld_addr, ld_data,
        output inst, inst_valid, addr_err, parity_err
    );
endinterface

// File: rtl/inst_rom.sv
// -----------------------------------------------------------------------------
// inst_rom -- instruction memory responder for the fetch stage.
//
// Holds the program image in a word array written through the boot-load port
// and returns one registered instruction per cycle (1-cycle latency).
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset (clears outputs, not the memory)
//   bus  : inst_rom_if.slave -- fetch request, stall, load port, response
//
// Optional feature macro: INST_ROM_PARITY_EN
//   defined   -> an even-parity bit is stored per word and checked on fetch
//   undefined -> no parity storage, parity_err is constant 0
// -----------------------------------------------------------------------------
module inst_rom #(
    parameter int DEPTH_LOG2 = 10,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    inst_rom_if.slave bus
);
    localparam int WORDS = 1 << DEPTH_LOG2;

    typedef enum logic {
        EMPTY = 1'b0,
        VALID = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] mem [WORDS];
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  hold;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  bad_addr;
    logic                  word_shown;

    state_t state_reg, state_next;
    logic   addr_err_reg, addr_err_next;

    // Only the IF-stage hold bit is meaningful to this block.
    logic unused_stall;
    assign unused_stall = ^{bus.stall[5:2], bus.stall[0]};

    assign hold       = bus.stall[1];
    assign rd_idx     = bus.addr[DEPTH_LOG2+1:2];
    assign misaligned = |bus.addr[1:0];

    // Upper address bits beyond the array must all be zero; when the address
    // bus is exactly as wide as the array there is nothing to check.
    generate
        if (ADDR_WIDTH > DEPTH_LOG2 + 2) begin : g_range
            assign out_of_range = |bus.addr[ADDR_WIDTH-1:DEPTH_LOG2+2];
        end else begin : g_no_range
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign bad_addr = misaligned | out_of_range;

    // Boot-load write: independent of reset, stall and fetch state.
    always_ff @(posedge clk) begin
        if (bus.ld_we) begin
            mem[bus.ld_addr] <= bus.ld_data;
        end
    end

    // Read register has an enable and no reset so the array maps onto block
    // RAM. Non-blocking semantics make a same-edge load/fetch read-before-write.
    // Whether the word is actually presented is decided by the state registers,
    // which carry the asynchronous reset.
    always_ff @(posedge clk) begin
        if (!hold) begin
            rd_data_reg <= mem[rd_idx];
        end
    end

    // Output FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= EMPTY;
            addr_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_err_reg <= addr_err_next;
        end
    end

    // Output FSM: next state, in priority order stall > ce=0 > good > bad
    always_comb begin
        state_next    = state_reg;
        addr_err_next = addr_err_reg;
        if (!hold) begin
            if (!bus.ce) begin
                state_next    = EMPTY;
                addr_err_next = 1'b0;
            end else if (bad_addr) begin
                state_next    = VALID;
                addr_err_next = 1'b1;
            end else begin
                state_next    = VALID;
                addr_err_next = 1'b0;
            end
        end
    end

    // A stored word is visible only for a valid, good-address fetch; every
    // other case (empty, bad address, reset) presents a NOP of zero.
    assign word_shown     = (state_reg == VALID) && !addr_err_reg;
    assign bus.inst       = word_shown ? rd_data_reg : '0;
    assign bus.inst_valid = (state_reg == VALID);
    assign bus.addr_err   = addr_err_reg;

`ifdef INST_ROM_PARITY_EN
    logic par_mem [WORDS];
    logic par_rd_reg;

    // Even parity: stored bit equals XOR of the data bits.
    always_ff @(posedge clk) begin
        if (bus.ld_we) begin
            par_mem[bus.ld_addr] <= ^bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!hold) begin
            par_rd_reg <= par_mem[rd_idx];
        end
    end

    // Held registers keep the flag frozen under stall; gating with
    // word_shown clears it for ce=0, bad address and reset.
    assign bus.parity_err = word_shown && ((^rd_data_reg) != par_rd_reg);
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_rom.sv
`timescale 1ns/1ps
module tb_inst_rom;
    localparam int DL = 10;
    localparam int AW = 32;
    localparam int DW = 32;

`ifdef INST_ROM_PARITY_EN
    localparam logic PERR_EXP = 1'b1;
`else
    localparam logic PERR_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_rom_if #(.DEPTH_LOG2(DL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    inst_rom #(.DEPTH_LOG2(DL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic        stall1;
        logic        ld_we;
        logic [9:0]  ld_addr;
        logic [31:0] ld_data;
        logic [31:0] exp_inst;
        logic        exp_valid;
        logic        exp_aerr;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic        valid;
        logic        aerr;
        logic        perr;
        int          tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ce, input logic [31:0] addr, input logic stall1,
                         input logic ld_we, input logic [9:0] ld_addr, input logic [31:0] ld_data);
        bus.ce      = ce;
        bus.addr    = addr;
        bus.stall   = {4'b0000, stall1, 1'b0};
        bus.ld_we   = ld_we;
        bus.ld_addr = ld_addr;
        bus.ld_data = ld_data;
    endtask

    task automatic push(input logic [31:0] inst, input logic valid, input logic aerr,
                        input logic perr, input int tag);
        exp_t e;
        e.inst = inst; e.valid = valid; e.aerr = aerr; e.perr = perr; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            check($sformatf("t%0d inst", e.tag),       bus.inst,       e.inst);
            check($sformatf("t%0d inst_valid", e.tag), {31'b0, bus.inst_valid}, {31'b0, e.valid});
            check($sformatf("t%0d addr_err", e.tag),   {31'b0, bus.addr_err},   {31'b0, e.aerr});
            check($sformatf("t%0d parity_err", e.tag), {31'b0, bus.parity_err}, {31'b0, e.perr});
            $display("[TB] t%0d ce=%0b addr=0x%08h stall1=%0b -> inst=0x%08h valid=%0b aerr=%0b perr=%0b",
                     e.tag, bus.ce, bus.addr, bus.stall[1], bus.inst, bus.inst_valid,
                     bus.addr_err, bus.parity_err);
        end
    endtask

    task automatic add(input logic ce, input logic [31:0] addr, input logic stall1,
                       input logic ld_we, input logic [9:0] ld_addr, input logic [31:0] ld_data,
                       input logic [31:0] exp_inst, input logic exp_valid, input logic exp_aerr);
        vec_t v;
        v.ce = ce; v.addr = addr; v.stall1 = stall1;
        v.ld_we = ld_we; v.ld_addr = ld_addr; v.ld_data = ld_data;
        v.exp_inst = exp_inst; v.exp_valid = exp_valid; v.exp_aerr = exp_aerr;
        vecs.push_back(v);
    endtask

    // One transaction: drive, record expectation, clock, compare after the edge.
    task automatic run_txn(input logic ce, input logic [31:0] addr, input logic stall1,
                           input logic ld_we, input logic [9:0] ld_addr, input logic [31:0] ld_data,
                           input logic [31:0] exp_inst, input logic exp_valid, input logic exp_aerr,
                           input logic exp_perr, input int tag);
        drive(ce, addr, stall1, ld_we, ld_addr, ld_data);
        push(exp_inst, exp_valid, exp_aerr, exp_perr, tag);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //   ce  addr          st ld  ldaddr  ld_data        exp_inst      v  aerr
        add(0, 32'h0000_0000, 0, 1, 10'd0,    32'h3401_0001, 32'h0,        0, 0);
        add(0, 32'h0000_0000, 0, 1, 10'd1,    32'h3402_0002, 32'h0,        0, 0);
        add(0, 32'h0000_0000, 0, 1, 10'd2,    32'h3403_0003, 32'h0,        0, 0);
        add(0, 32'h0000_0000, 0, 1, 10'd3,    32'h3404_0004, 32'h0,        0, 0);
        add(0, 32'h0000_0000, 0, 1, 10'd5,    32'hAAAA_0000, 32'h0,        0, 0);
        add(1, 32'h0000_0000, 0, 0, 10'd0,    32'h0,         32'h3401_0001, 1, 0);
        add(1, 32'h0000_0004, 0, 0, 10'd0,    32'h0,         32'h3402_0002, 1, 0);
        add(1, 32'h0000_0008, 1, 0, 10'd0,    32'h0,         32'h3402_0002, 1, 0);
        add(1, 32'h0000_0008, 1, 0, 10'd0,    32'h0,         32'h3402_0002, 1, 0);
        add(1, 32'h0000_000C, 1, 0, 10'd0,    32'h0,         32'h3402_0002, 1, 0);
        add(1, 32'h0000_000C, 0, 0, 10'd0,    32'h0,         32'h3404_0004, 1, 0);
        add(1, 32'h0000_0008, 0, 0, 10'd0,    32'h0,         32'h3403_0003, 1, 0);
        add(1, 32'h0000_000C, 0, 0, 10'd0,    32'h0,         32'h3404_0004, 1, 0);
        add(1, 32'h0000_0002, 0, 0, 10'd0,    32'h0,         32'h0,        1, 1);
        add(1, 32'h0000_1000, 0, 0, 10'd0,    32'h0,         32'h0,        1, 1);
        add(0, 32'h0000_0000, 0, 0, 10'd0,    32'h0,         32'h0,        0, 0);
        add(1, 32'h0000_0000, 0, 0, 10'd0,    32'h0,         32'h3401_0001, 1, 0);
        add(0, 32'h0000_0003, 1, 0, 10'd0,    32'h0,         32'h3401_0001, 1, 0);
        add(1, 32'h0000_0014, 0, 1, 10'd5,    32'h5555_FFFF, 32'hAAAA_0000, 1, 0);
        add(1, 32'h0000_0014, 0, 0, 10'd0,    32'h0,         32'h5555_FFFF, 1, 0);
        add(1, 32'h8000_0000, 0, 0, 10'd0,    32'h0,         32'h0,        1, 1);
        add(0, 32'h0000_0000, 0, 1, 10'd1023, 32'hDEAD_BEEF, 32'h0,        0, 0);
        add(1, 32'h0000_0FFC, 0, 0, 10'd0,    32'h0,         32'hDEAD_BEEF, 1, 0);

        // Reset state
        rst = 1'b0;
        drive(0, 32'h0, 0, 0, 10'd0, 32'h0);
        #2;
        check("reset inst",       bus.inst,                 32'h0);
        check("reset inst_valid", {31'b0, bus.inst_valid},  32'h0);
        check("reset addr_err",   {31'b0, bus.addr_err},    32'h0);
        check("reset parity_err", {31'b0, bus.parity_err},  32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        foreach (vecs[i]) begin
            run_txn(vecs[i].ce, vecs[i].addr, vecs[i].stall1, vecs[i].ld_we,
                    vecs[i].ld_addr, vecs[i].ld_data, vecs[i].exp_inst,
                    vecs[i].exp_valid, vecs[i].exp_aerr, 1'b0, i);
        end

        // Asynchronous reset mid-cycle while streaming
        run_txn(1, 32'h0, 0, 0, 10'd0, 32'h0, 32'h3401_0001, 1, 0, 0, 100);
        drive(1, 32'h4, 0, 0, 10'd0, 32'h0);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst inst",       bus.inst,                32'h0);
        check("async_rst inst_valid", {31'b0, bus.inst_valid}, 32'h0);
        check("async_rst addr_err",   {31'b0, bus.addr_err},   32'h0);
        // Load during reset is still performed; fetch is discarded
        drive(1, 32'h4, 0, 1, 10'd6, 32'h1234_5678);
        @(posedge clk);
        #1;
        check("in_rst inst",       bus.inst,                32'h0);
        check("in_rst inst_valid", {31'b0, bus.inst_valid}, 32'h0);
        rst = 1'b1;
        run_txn(1, 32'h0000_0000, 0, 0, 10'd0, 32'h0, 32'h3401_0001, 1, 0, 0, 101);
        run_txn(1, 32'h0000_0018, 0, 0, 10'd0, 32'h0, 32'h1234_5678, 1, 0, 0, 102);

        // Parity corruption on word 2 (backdoor only when the feature exists)
`ifdef INST_ROM_PARITY_EN
        dut.par_mem[2] = ~dut.par_mem[2];
`endif
        run_txn(1, 32'h0000_0008, 0, 0, 10'd0, 32'h0, 32'h3403_0003, 1, 0, PERR_EXP, 103);
        run_txn(1, 32'h0000_0008, 1, 0, 10'd0, 32'h0, 32'h3403_0003, 1, 0, PERR_EXP, 104);
        run_txn(0, 32'h0000_0008, 0, 0, 10'd0, 32'h0, 32'h0,         0, 0, 0, 105);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/inst_rom.md
# inst_rom

Instruction-memory responder for the fetch interface: the slave end of the PC generator's `pc`/`ce` request pair. It holds the program image in an internal word array filled through a boot-load port, and returns one registered instruction word per cycle to the IF/ID stage. It honours the pipeline `stall` vector and flags bad fetch addresses. It sits between the PC register and the IF/ID pipeline register.

## Interface
- `DEPTH_LOG2`, default 10: log2 of the word count (default 1024 words, 4 KiB).
- `ADDR_WIDTH`, default 32: fetch address width (`InstAddrBus`).
- `DATA_WIDTH`, default 32: instruction width (`InstBus`).

Ports:
- `clk`  in  1  — sole clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-low reset (0 = reset).
- `ce`  in  1  — fetch enable from the PC register (`ChipEnable` = 1).
- `addr`  in  ADDR_WIDTH  — byte fetch address (the PC).
- `stall`  in  6  — pipeline stall vector; this block uses only `stall[1]` (IF stage hold).
- `ld_we`  in  1  — boot-load write strobe.
- `ld_addr`  in  DEPTH_LOG2  — boot-load word index.
- `ld_data`  in  DATA_WIDTH  — boot-load word.
- `inst`  out  DATA_WIDTH  — fetched instruction, registered.
- `inst_valid`  out  1  — `inst` holds a real fetched word.
- `addr_err`  out  1  — the current `inst` came from a misaligned or out-of-range fetch.
- `parity_err`  out  1  — a stored-word parity mismatch was seen on the current `inst` (tied 0 when the feature is compiled out).

## Operation
- Word index is `addr[DEPTH_LOG2+1:2]`.
- An address is bad if `addr[1:0] != 0`, or if any bit of `addr[ADDR_WIDTH-1:DEPTH_LOG2+2]` is 1.
- Output state machine, two states, encoded by `inst_valid`:
  - **EMPTY** (`inst_valid` = 0). This is the reset state.
  - **VALID** (`inst_valid` = 1).
- Transitions at each rising edge, in priority order:
  1. `stall[1]` = 1: hold the state and all outputs unchanged; `addr` and `ce` are ignored.
  2. `ce` = 0: go to EMPTY; `inst`, `addr_err` and `parity_err` go to 0.
  3. `ce` = 1 with a good address: go to VALID; `inst` = mem[index]; `addr_err` = 0.
  4. `ce` = 1 with a bad address: go to VALID; `inst` = 0 (NOP); `addr_err` = 1.
- Load port:
  - On any edge with `ld_we` = 1, mem[`ld_addr`] <= `ld_data`. This happens regardless of `ce`, `stall` and fetch state.
  - Load and fetch to the same word on the same edge are read-before-write: the fetch returns the old word and the new word is visible from the next fetch.
- Memory contents are not cleared by reset; they persist across `rst` pulses. Contents before the first load are undefined.

## Timing
- Fetch latency is 1 cycle: the address sampled at edge N appears on `inst` after edge N and stays stable until edge N+1.
- This matches the PC register's behaviour: the PC that is current between edges N-1 and N is sampled at N.
- Throughput is one fetch per cycle with no bubbles while `ce` = 1 and `stall[1]` = 0.
- Stall: while `stall[1]` = 1, outputs are frozen for every stalled cycle. On the first unstalled edge, the then-current `addr` is fetched; no address is buffered during the stall.
- Reset:
  - `rst` falling clears `inst`, `inst_valid`, `addr_err` and `parity_err` to 0 immediately, without waiting for a clock edge.
  - A fetch in flight during reset is discarded.
  - A load strobe on an edge while `rst` = 0 is still performed. Memory is not under reset.
- Release: the first edge with `rst` = 1 evaluates normally.

## Configuration
- Macro: `INST_ROM_PARITY_EN`.
- Defined:
  - Each word stores an extra even-parity bit computed from `ld_data` at load time.
  - A good-address fetch recomputes parity; `parity_err` = 1 on mismatch. `inst` still returns the stored word.
  - `parity_err` holds with the other outputs under stall and clears on `ce` = 0, a bad address, or reset.
- Undefined: no parity storage; `parity_err` is constant 0.

## Test plan
- Load mem[0..3] = 0x34010001, 0x34020002, 0x34030003, 0x34040004. Drive `ce` = 1 with `addr` = 0, 4, 8, 0xC on consecutive edges → `inst` shows the four words one cycle later, with `inst_valid` = 1 and `addr_err` = 0.
- Mid-sequence, set `stall[1]` = 1 for 3 cycles while `addr` moves from 8 to 0xC → `inst` stays 0x34020002 through all 3 cycles, then 0x34040004 is returned for `addr` 0xC.
- Fetch `addr` = 0x2 → `inst` = 0, `addr_err` = 1. Then fetch `addr` = 0x1000 with DEPTH_LOG2 = 10 → `inst` = 0, `addr_err` = 1.
- On the same edge, fetch word 5 (old value 0xAAAA0000) and load word 5 = 0x5555FFFF → returns 0xAAAA0000; the next fetch of word 5 returns 0x5555FFFF.
- Assert `rst` = 0 asynchronously mid-cycle during streaming → all outputs read 0 before the next edge. After release with `ce` = 1, `addr` = 0 → returns 0x34010001 (memory preserved).
- With `INST_ROM_PARITY_EN` defined, force a stored parity bit flip on word 2 (bench backdoor), then fetch `addr` = 8 → `parity_err` = 1 and `inst` = the stored word. Without the macro → `parity_err` = 0 throughout.
